// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Shares a single-port, fixed-latency SRAM between the instruction-fetch
//   port and the data port of the pipeline. A request is latched when it is
//   granted and held on the SRAM for WAIT_CYCLES cycles. The requester then
//   receives a one-cycle ready pulse, followed by one turnaround cycle in IDLE.
//   When both ports ask at once, the port that was not granted last wins.
//
// Parameters
//   WAIT_CYCLES  SRAM access time in cycles (>= 1)
//   ADDR_WIDTH   address width
//   DATA_WIDTH   data width
//
// Ports
//   clk, rst                 clock, asynchronous active-low reset
//   if_req/if_addr           fetch request (held until if_ready) and address
//   if_rdata/if_ready        registered fetch data, one-cycle completion pulse
//   mem_read_en/mem_write_en data request levels (both high = write)
//   mem_addr/mem_wdata       data address and store data
//   mem_rdata/mem_ready      registered load data, one-cycle completion pulse
//   sram_en/sram_we          SRAM access strobe and write strobe
//   sram_addr/sram_wdata     latched address and store data
//   sram_rdata               SRAM read data, valid in the last wait cycle
//   if_stall/mem_stall       pipeline freeze while a request is unanswered
module mem_port_arbiter #(
  parameter int WAIT_CYCLES = 3,
  parameter int ADDR_WIDTH  = 32,
  parameter int DATA_WIDTH  = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  if_req,
  input  logic [ADDR_WIDTH-1:0] if_addr,
  output logic [DATA_WIDTH-1:0] if_rdata,
  output logic                  if_ready,
  input  logic                  mem_read_en,
  input  logic                  mem_write_en,
  input  logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic [DATA_WIDTH-1:0] mem_wdata,
  output logic [DATA_WIDTH-1:0] mem_rdata,
  output logic                  mem_ready,
  output logic                  sram_en,
  output logic                  sram_we,
  output logic [ADDR_WIDTH-1:0] sram_addr,
  output logic [DATA_WIDTH-1:0] sram_wdata,
  input  logic [DATA_WIDTH-1:0] sram_rdata,
  output logic                  if_stall,
  output logic                  mem_stall
);

  // Counter only has to reach WAIT_CYCLES-1; keep at least one bit.
  localparam int CNT_W = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WAIT_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    BUSY_IF  = 2'd1,
    BUSY_MEM = 2'd2,
    RESP     = 2'd3
  } state_t;

  // owner / last_grant encoding: 0 = fetch port, 1 = data port
  state_t                  state_q;
  logic [CNT_W-1:0]        cnt_q;
  logic                    last_grant_q;
  logic                    owner_q;
  logic                    we_q;
  logic [ADDR_WIDTH-1:0]   addr_q;
  logic [DATA_WIDTH-1:0]   wdata_q;
  logic [DATA_WIDTH-1:0]   if_rdata_q;
  logic [DATA_WIDTH-1:0]   mem_rdata_q;

  logic                    mem_pend_d;
  logic                    grant_any_d;
  logic                    grant_mem_d;
  logic                    busy;

  // Grant decision evaluated in IDLE. The data port wins when it asks alone.
  // On a conflict it wins only if the fetch port was granted last.
  always_comb begin
    mem_pend_d  = mem_read_en | mem_write_en;
    grant_any_d = mem_pend_d | if_req;
    grant_mem_d = mem_pend_d & (~if_req | ~last_grant_q);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      last_grant_q <= 1'b0;
      owner_q      <= 1'b0;
      we_q         <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      if_rdata_q   <= '0;
      mem_rdata_q  <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (grant_any_d) begin
            state_q      <= grant_mem_d ? BUSY_MEM : BUSY_IF;
            cnt_q        <= '0;
            owner_q      <= grant_mem_d;
            last_grant_q <= grant_mem_d;
            // A fetch is always a read; read+write on the data port is a write.
            we_q         <= grant_mem_d & mem_write_en;
            addr_q       <= grant_mem_d ? mem_addr : if_addr;
            if (grant_mem_d) begin
              wdata_q <= mem_wdata;
            end
          end
        end
        BUSY_IF, BUSY_MEM: begin
          if (cnt_q == CNT_LAST) begin
            state_q <= RESP;
            cnt_q   <= '0;
            if (!we_q) begin
              if (owner_q) begin
                mem_rdata_q <= sram_rdata;
              end else begin
                if_rdata_q  <= sram_rdata;
              end
            end
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        RESP: begin
          // Turnaround: the requester sees ready and may change its request.
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  // SRAM strobes and ready pulses come from state only; the SRAM address and
  // data come from the latched copies, so inputs never reach the SRAM directly.
  always_comb begin
    busy       = (state_q == BUSY_IF) || (state_q == BUSY_MEM);
    sram_en    = busy;
    sram_we    = busy & we_q;
    sram_addr  = addr_q;
    sram_wdata = wdata_q;
    if_ready   = (state_q == RESP) & ~owner_q;
    mem_ready  = (state_q == RESP) &  owner_q;
    if_rdata   = if_rdata_q;
    mem_rdata  = mem_rdata_q;
    if_stall   = if_req & ~if_ready;
    mem_stall  = (mem_read_en | mem_write_en) & ~mem_ready;
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;

  localparam int W  = 3;
  localparam int AW = 32;
  localparam int DW = 32;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- main DUT (WAIT_CYCLES = 3) ----------------
  logic          rst;
  logic          if_req;
  logic [AW-1:0] if_addr;
  logic [DW-1:0] if_rdata;
  logic          if_ready;
  logic          mem_read_en, mem_write_en;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;
  logic          mem_ready;
  logic          sram_en, sram_we;
  logic [AW-1:0] sram_addr;
  logic [DW-1:0] sram_wdata;
  logic [DW-1:0] sram_rdata;
  logic          if_stall, mem_stall;

  mem_port_arbiter #(.WAIT_CYCLES(W), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ready(if_ready),
    .mem_read_en(mem_read_en), .mem_write_en(mem_write_en), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
    .sram_en(sram_en), .sram_we(sram_we), .sram_addr(sram_addr),
    .sram_wdata(sram_wdata), .sram_rdata(sram_rdata),
    .if_stall(if_stall), .mem_stall(mem_stall)
  );

  // ---------------- second DUT (WAIT_CYCLES = 1) ----------------
  logic          rst1;
  logic          if_req1;
  logic [AW-1:0] if_addr1;
  logic [DW-1:0] if_rdata1;
  logic          if_ready1;
  logic          rd1, wr1;
  logic [AW-1:0] addr1;
  logic [DW-1:0] wdata1;
  logic [DW-1:0] mem_rdata1;
  logic          mem_ready1;
  logic          sram_en1, sram_we1;
  logic [AW-1:0] sram_addr1;
  logic [DW-1:0] sram_wdata1;
  logic [DW-1:0] sram_rdata1;
  logic          if_stall1, mem_stall1;

  mem_port_arbiter #(.WAIT_CYCLES(1), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut1 (
    .clk(clk), .rst(rst1),
    .if_req(if_req1), .if_addr(if_addr1), .if_rdata(if_rdata1), .if_ready(if_ready1),
    .mem_read_en(rd1), .mem_write_en(wr1), .mem_addr(addr1),
    .mem_wdata(wdata1), .mem_rdata(mem_rdata1), .mem_ready(mem_ready1),
    .sram_en(sram_en1), .sram_we(sram_we1), .sram_addr(sram_addr1),
    .sram_wdata(sram_wdata1), .sram_rdata(sram_rdata1),
    .if_stall(if_stall1), .mem_stall(mem_stall1)
  );

  assign sram_rdata1 = sram_en1 ? 32'h12345678 : 32'h0BAD0BAD;

  // ---------------- bookkeeping ----------------
  int checks   = 0;
  int failures = 0;
  int cyc      = 0;   // number of rising edges seen so far
  bit skip     = 1'b1;
  bit gen_en   = 1'b1;
  bit done1    = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (edge %0d)", name, act, exp, cyc);
    end
  endtask

  // SRAM contents as a fixed function of the address.
  function automatic logic [31:0] rom(input logic [31:0] a);
    if (a == 32'h40) return 32'hE3A01005;
    return (a * 32'h9E3779B1) ^ 32'hC3A50F1E;
  endfunction

  // SRAM model: data is valid only in the last wait cycle, garbage before.
  int            en_cnt = 0;
  logic [31:0]   junk   = 32'h0;
  always @(posedge clk) begin
    en_cnt <= sram_en ? en_cnt + 1 : 0;
    junk   <= $urandom;
  end
  assign sram_rdata = (sram_en && en_cnt == W - 1) ? rom(sram_addr) : junk;

  // ---------------- reference model ----------------
  typedef struct {
    bit          port_mem;
    int          t;         // sampling edge of the grant
    logic [31:0] addr;
    bit          we;
    logic [31:0] wdata;
  } txn_t;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] wdata;
    bit          rd;
    bit          wr;
  } mreq_t;

  txn_t        sb[$];
  logic [31:0] dir_if[$];
  mreq_t       dir_mem[$];
  int          next_free = 0;
  bit          last_mem  = 1'b0;
  logic [31:0] exp_if_rdata  = 32'h0;
  logic [31:0] exp_mem_rdata = 32'h0;
  int          st_if = 0, st_mem = 0;   // 0 idle, 1 waiting, 2 in flight
  int          done_if = 0, done_mem = 0;

  // Arbitration for the inputs that will be sampled at edge cyc+1.
  task automatic model_arb();
    int   e_smp;
    bit   ifp, mp, gm;
    txn_t t;
    e_smp = cyc + 1;
    ifp   = if_req;
    mp    = mem_read_en | mem_write_en;
    if (e_smp >= next_free && (ifp || mp)) begin
      gm        = mp && (!ifp || !last_mem);
      t.port_mem = gm;
      t.t        = e_smp;
      t.addr     = gm ? mem_addr : if_addr;
      t.we       = gm && mem_write_en;
      t.wdata    = mem_wdata;
      sb.push_back(t);
      last_mem  = gm;
      next_free = e_smp + W + 2;
      if (gm) begin st_mem = 2; done_mem = e_smp + W; end
      else    begin st_if  = 2; done_if  = e_smp + W; end
    end
  endtask

  task automatic model_reset();
    sb.delete();
    next_free     = 0;
    last_mem      = 1'b0;
    exp_if_rdata  = 32'h0;
    exp_mem_rdata = 32'h0;
  endtask

  // One requester step per cycle, called just after the rising edge.
  task automatic step_drive();
    int    r;
    mreq_t m;
    if (st_if == 2 && cyc == done_if) begin st_if = 0; if_req = 1'b0; end
    if (st_mem == 2 && cyc == done_mem) begin
      st_mem = 0; mem_read_en = 1'b0; mem_write_en = 1'b0;
    end
    if (st_if == 0 && gen_en) begin
      if (dir_if.size() > 0) begin
        if_addr = dir_if.pop_front(); if_req = 1'b1; st_if = 1;
      end else if ($urandom_range(0, 99) < 60) begin
        if_addr = $urandom & 32'hFFFC; if_req = 1'b1; st_if = 1;
      end
    end else if (st_if == 2) begin
      if ($urandom_range(0, 3) == 0) if_addr = $urandom;
      if ($urandom_range(0, 7) == 0) if_req = 1'b0;
    end
    if (st_mem == 0 && gen_en) begin
      if (dir_mem.size() > 0) begin
        m = dir_mem.pop_front();
        mem_addr = m.addr; mem_wdata = m.wdata;
        mem_read_en = m.rd; mem_write_en = m.wr; st_mem = 1;
      end else if ($urandom_range(0, 99) < 60) begin
        r = $urandom_range(0, 3);
        mem_addr     = $urandom & 32'hFFFC;
        mem_wdata    = $urandom;
        mem_read_en  = (r != 2);
        mem_write_en = (r >= 2);
        st_mem = 1;
      end
    end else if (st_mem == 2) begin
      if ($urandom_range(0, 3) == 0) begin mem_addr = $urandom; mem_wdata = $urandom; end
      if ($urandom_range(0, 7) == 0) begin mem_read_en = 1'b0; mem_write_en = 1'b0; end
    end
    model_arb();
  endtask

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk) begin
    if (!skip) begin
      bit          act, rif, rmem, we_f;
      logic [31:0] a_f, wd_f;
      act = 0; rif = 0; rmem = 0; we_f = 0; a_f = 0; wd_f = 0;
      if (sb.size() > 0) begin
        a_f  = sb[0].addr;
        we_f = sb[0].we;
        wd_f = sb[0].wdata;
        if (cyc >= sb[0].t && cyc < sb[0].t + W) act = 1;
        if (cyc == sb[0].t + W) begin
          rif  = !sb[0].port_mem;
          rmem =  sb[0].port_mem;
        end
      end
      chk("sram_en", sram_en, act);
      chk("sram_we", sram_we, act && we_f);
      if (act) begin
        chk("sram_addr", sram_addr, a_f);
        if (we_f) chk("sram_wdata", sram_wdata, wd_f);
      end
      chk("if_ready", if_ready, rif);
      chk("mem_ready", mem_ready, rmem);
      if (rif && !we_f)  exp_if_rdata  = rom(a_f);
      if (rmem && !we_f) exp_mem_rdata = rom(a_f);
      chk("if_rdata", if_rdata, exp_if_rdata);
      chk("mem_rdata", mem_rdata, exp_mem_rdata);
      chk("if_stall", if_stall, if_req & ~rif);
      chk("mem_stall", mem_stall, (mem_read_en | mem_write_en) & ~rmem);
      if ((if_ready || mem_ready || rif || rmem) && sb.size() > 0) void'(sb.pop_front());
    end
  end

  // ---------------- main stimulus ----------------
  initial begin
    mreq_t m;
    rst = 1'b0;
    if_req = 1'b0; if_addr = '0;
    mem_read_en = 1'b0; mem_write_en = 1'b0; mem_addr = '0; mem_wdata = '0;
    dir_if.push_back(32'h40);
    m.addr = 32'h100; m.wdata = 32'hDEADBEEF; m.rd = 1'b0; m.wr = 1'b1;
    dir_mem.push_back(m);

    repeat (2) @(posedge clk);
    #1;
    chk("rst_sram_en", sram_en, 0);
    chk("rst_sram_we", sram_we, 0);
    chk("rst_sram_addr", sram_addr, 0);
    chk("rst_sram_wdata", sram_wdata, 0);
    chk("rst_if_rdata", if_rdata, 0);
    chk("rst_mem_rdata", mem_rdata, 0);
    chk("rst_if_ready", if_ready, 0);
    chk("rst_mem_ready", mem_ready, 0);
    @(negedge clk);
    rst = 1'b1;
    step_drive();

    for (int i = 0; i < 1500; i++) begin
      @(posedge clk); #1;
      skip = 1'b0;
      step_drive();
    end

    // Drain outstanding traffic before the reset scenario.
    gen_en = 1'b0;
    for (int i = 0; i < 60 && (sb.size() != 0 || st_if != 0 || st_mem != 0); i++) begin
      @(posedge clk); #1;
      step_drive();
    end
    chk("drain_empty", sb.size(), 0);

    // Fetch, then reset in its second busy cycle.
    if_req = 1'b1; if_addr = 32'h80; st_if = 1;
    model_arb();
    @(posedge clk); #1;   // busy cycle 1
    @(posedge clk); #1;   // busy cycle 2
    skip = 1'b1;
    rst  = 1'b0;
    #1;
    chk("midrst_sram_en", sram_en, 0);
    chk("midrst_sram_addr", sram_addr, 0);
    chk("midrst_if_ready", if_ready, 0);
    chk("midrst_if_rdata", if_rdata, 0);
    chk("midrst_mem_rdata", mem_rdata, 0);
    chk("midrst_if_stall", if_stall, 1);
    model_reset();
    st_if = 1;            // request still held by the fetch stage
    @(negedge clk);
    rst = 1'b1;
    model_arb();
    for (int i = 0; i < W + 6; i++) begin
      @(posedge clk); #1;
      skip = 1'b0;
      step_drive();
    end
    chk("regrant_complete", sb.size(), 0);
    chk("regrant_if_rdata", if_rdata, rom(32'h80));

    for (int i = 0; i < 100 && !done1; i++) @(posedge clk);
    chk("w1_done", done1, 1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // ---------------- WAIT_CYCLES = 1 directed read ----------------
  initial begin
    rst1 = 1'b0; if_req1 = 1'b0; if_addr1 = '0;
    rd1 = 1'b0; wr1 = 1'b0; addr1 = '0; wdata1 = '0;
    repeat (3) @(posedge clk);
    #1;
    rst1 = 1'b1;
    @(posedge clk); #1;
    rd1 = 1'b1; addr1 = 32'h8;
    @(posedge clk); #1;   // sampled at this edge: single busy cycle
    chk("w1_sram_en", sram_en1, 1);
    chk("w1_sram_addr", sram_addr1, 32'h8);
    chk("w1_ready_early", mem_ready1, 0);
    chk("w1_stall_busy", mem_stall1, 1);
    @(posedge clk); #1;   // second cycle after sampling: ready
    chk("w1_mem_ready", mem_ready1, 1);
    chk("w1_mem_rdata", mem_rdata1, 32'h12345678);
    chk("w1_sram_en_off", sram_en1, 0);
    chk("w1_stall_ready", mem_stall1, 0);
    rd1 = 1'b0;
    @(posedge clk); #1;
    chk("w1_ready_pulse", mem_ready1, 0);
    chk("w1_rdata_hold", mem_rdata1, 32'h12345678);
    chk("w1_if_side", {if_ready1, if_stall1, sram_we1}, 0);
    chk("w1_if_rdata", if_rdata1, 0);
    chk("w1_sram_wdata", sram_wdata1, 0);
    done1 = 1'b1;
  end

  // ---------------- watchdog ----------------
  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit, got no finish, expected finish");
    $fatal(1);
  end

endmodule
